// File: rtl/cordic_pkg.sv
// Shared hyperbolic CORDIC definitions: atanh table, iteration count, default width, FSM states.
package cordic_pkg;

    localparam int XY_SZ_DEFAULT = 8;
    localparam int ITER_DEFAULT  = 7;
    localparam int ATANH_W       = 5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // atanh(2^-(idx+1)) in the angle LSB shared with the rotation pipeline
    function automatic logic [ATANH_W-1:0] atanh_lut(input int unsigned idx);
        logic [ATANH_W-1:0] v;
        v = '0;
        case (idx)
            0: v = 5'd22;
            1: v = 5'd10;
            2: v = 5'd5;
            3: v = 5'd2;
            4: v = 5'd1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_hyp_microrot.sv
// One combinational hyperbolic micro-rotation; direction from Z sign (rotation) or Y sign (vectoring).
module cordic_hyp_microrot #(
    parameter int W    = 9,
    parameter int SH_W = 3
) (
    input  logic signed [W-1:0]    x,
    input  logic signed [W-1:0]    y,
    input  logic signed [W-1:0]    z,
    input  logic        [SH_W-1:0] shift,
    input  logic signed [W-1:0]    t,
    input  logic                   vectoring,
    output logic signed [W-1:0]    x_nx,
    output logic signed [W-1:0]    y_nx,
    output logic signed [W-1:0]    z_nx
);

    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;
    logic                up;

    always_comb begin
        x_sh = x >>> shift;
        y_sh = y >>> shift;
        up   = vectoring ? y[W-1] : ~z[W-1];
        if (up) begin
            x_nx = x + y_sh;
            y_nx = y + x_sh;
            z_nx = z - t;
        end else begin
            x_nx = x - y_sh;
            y_nx = y - x_sh;
            z_nx = z + t;
        end
    end

endmodule

// File: rtl/cordic_hyperbolic_vectoring_8bit.sv
// Iterative hyperbolic CORDIC vectoring: one shared micro-rotation, ITER cycles per operand.
module cordic_hyperbolic_vectoring_8bit
    import cordic_pkg::*;
#(
    parameter int XY_SZ = XY_SZ_DEFAULT,
    parameter int ITER  = ITER_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [XY_SZ-1:0] Xin,
    input  logic signed [XY_SZ-1:0] Yin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [XY_SZ:0]   Xout,
    output logic signed [XY_SZ-1:0] Zout,
    output logic                    dom_err
);

    localparam int W    = XY_SZ + 1;
    localparam int SH_W = $clog2(ITER + 1);

    state_t              state, state_nx;
    logic [SH_W-1:0]     cnt;
    logic [SH_W-1:0]     shift;
    logic                last;
    logic signed [W-1:0] x_r, y_r, z_r;
    logic signed [W-1:0] x_nx, y_nx, z_nx;
    logic signed [W-1:0] x_in_e, y_in_e, y_abs, t;
    logic                dom_now, dom_r;

    assign x_in_e  = {Xin[XY_SZ-1], Xin};
    assign y_in_e  = {Yin[XY_SZ-1], Yin};
    assign y_abs   = y_in_e[W-1] ? -y_in_e : y_in_e;
    assign dom_now = x_in_e[W-1] || (x_in_e == '0) || (y_abs >= x_in_e);

    assign shift = cnt + SH_W'(1);
    assign last  = (cnt == SH_W'(ITER - 1));
    assign t     = {{(W - ATANH_W){1'b0}}, atanh_lut(32'(cnt))};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    cordic_hyp_microrot #(.W(W), .SH_W(SH_W)) u_microrot (
        .x         (x_r),
        .y         (y_r),
        .z         (z_r),
        .shift     (shift),
        .t         (t),
        .vectoring (1'b1),
        .x_nx      (x_nx),
        .y_nx      (y_nx),
        .z_nx      (z_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (last)     state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // dom_err is captured at acceptance but only published with the result
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            dom_r   <= 1'b0;
            Xout    <= '0;
            Zout    <= '0;
            dom_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x_r   <= x_in_e;
                    y_r   <= y_in_e;
                    z_r   <= '0;
                    dom_r <= dom_now;
                    cnt   <= '0;
                end
                RUN: begin
                    x_r <= x_nx;
                    y_r <= y_nx;
                    z_r <= z_nx;
                    if (last) begin
                        Xout    <= x_nx;
                        Zout    <= z_nx[XY_SZ-1:0];
                        dom_err <= dom_r;
                    end else begin
                        cnt <= cnt + SH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_hyperbolic_vectoring_8bit.sv
// Self-checking bench: directed cases, backpressure, mid-run reset and a random stream vs. an arithmetic model.
module tb_cordic_hyperbolic_vectoring_8bit;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] Xin;
    logic signed [7:0] Yin;
    logic              out_valid;
    logic              out_ready;
    logic signed [8:0] Xout;
    logic signed [7:0] Zout;
    logic              dom_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cordic_hyperbolic_vectoring_8bit #(.XY_SZ(8), .ITER(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Xin       (Xin),
        .Yin       (Yin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Xout      (Xout),
        .Zout      (Zout),
        .dom_err   (dom_err)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int wrap(input int v, input int bits);
        int m;
        m = v & ((1 << bits) - 1);
        if (m >= (1 << (bits - 1))) m -= (1 << bits);
        return m;
    endfunction

    // Reference: ITER micro-rotations on plain integers, 9-bit wrapping X/Y
    task automatic model(input int xin, input int yin, output int xo, output int zo, output int de);
        int tab[7] = '{22, 10, 5, 2, 1, 0, 0};
        int x, y, z, xn, yn, ay;
        x = xin; y = yin; z = 0;
        for (int i = 0; i < 7; i++) begin
            if (y >= 0) begin
                xn = x - (y >>> (i + 1)); yn = y - (x >>> (i + 1)); z = z + tab[i];
            end else begin
                xn = x + (y >>> (i + 1)); yn = y + (x >>> (i + 1)); z = z - tab[i];
            end
            x = wrap(xn, 9); y = wrap(yn, 9);
        end
        ay = (yin < 0) ? -yin : yin;
        xo = x;
        zo = wrap(z, 8);
        de = (xin <= 0 || ay >= xin) ? 1 : 0;
    endtask

    // Issues one operand, waits for the result and checks latency and values; leaves DONE held
    task automatic issue(input int x, input int y, output int xo, output int zo, output int de);
        int lat, k;
        int ex, ez, ed;
        k = 0;
        while (!in_ready && k < 30) begin @(negedge clk); k++; end
        check("ready_wait", int'(in_ready), 1);
        Xin = 8'(x); Yin = 8'(y); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        check("latency", lat, 7);
        model(x, y, ex, ez, ed);
        xo = int'(Xout); zo = int'(Zout); de = int'(dom_err);
        check("xout", xo, ex);
        check("zout", zo, ez);
        check("dom_err", de, ed);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_ready", int'(in_ready), 1);
        check("idle_valid", int'(out_valid), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        int xo, zo, de, x, y, sx, sz;
        int exq_x[$], exq_z[$], exq_d[$];
        int sent, got, last_cyc, cyc, ex, ez, ed;
        bit change;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; Xin = '0; Yin = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_xout", int'(Xout), 0);
        check("rst_zout", int'(Zout), 0);
        check("rst_dom_err", int'(dom_err), 0);

        issue(64, 0, xo, zo, de);
        check("x64_xout", xo, 50);
        check("x64_zout", zo, 4);
        check("x64_dom", de, 0);
        release_result();

        issue(100, 50, xo, zo, de);
        check("half_ztol", (zo >= 19 && zo <= 25) ? 1 : 0, 1);
        check("half_dom", de, 0);
        release_result();

        issue(-10, 0, xo, zo, de);
        check("negx_dom", de, 1);
        release_result();
        issue(20, 20, xo, zo, de);
        check("edge_dom", de, 1);

        // Backpressure: result frozen, new operands ignored
        sx = int'(Xout); sz = int'(Zout);
        in_valid = 1'b1; Xin = 8'sd90; Yin = -8'sd30;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", int'(out_valid), 1);
            check("bp_ready", int'(in_ready), 0);
            check("bp_xout", int'(Xout), sx);
            check("bp_zout", int'(Zout), sz);
            check("bp_dom", int'(dom_err), 1);
        end
        in_valid = 1'b0;
        release_result();

        for (int i = 0; i < 8; i++) begin
            x = int'($urandom_range(0, 255)) - 128;
            y = int'($urandom_range(0, 255)) - 128;
            issue(x, y, xo, zo, de);
            release_result();
        end

        // Reset at iteration 3
        Xin = 8'sd77; Yin = 8'sd33; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", int'(in_ready), 1);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_xout", int'(Xout), 0);
        check("mid_rst_zout", int'(Zout), 0);
        issue(77, 33, xo, zo, de);
        release_result();

        // Streaming with out_ready held high
        out_ready = 1'b1;
        sent = 0; got = 0; last_cyc = -1; change = 1'b1;
        for (cyc = 0; cyc < 400 && got < 20; cyc++) begin
            if (out_valid) begin
                if (exq_x.size() == 0) begin
                    check("stream_unexpected", 1, 0);
                end else begin
                    ex = exq_x.pop_front(); ez = exq_z.pop_front(); ed = exq_d.pop_front();
                    check("stream_xout", int'(Xout), ex);
                    check("stream_zout", int'(Zout), ez);
                    check("stream_dom", int'(dom_err), ed);
                end
                if (last_cyc >= 0) check("stream_ii", cyc - last_cyc, 9);
                last_cyc = cyc;
                got++;
            end
            if (change) begin
                if (sent < 20) begin
                    x = int'($urandom_range(1, 127));
                    y = int'($urandom_range(0, 2 * x - 2)) - (x - 1);
                    Xin = 8'(x); Yin = 8'(y); in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                change = 1'b0;
            end
            if (in_ready && in_valid) begin
                model(int'(Xin), int'(Yin), ex, ez, ed);
                exq_x.push_back(ex); exq_z.push_back(ez); exq_d.push_back(ed);
                sent++;
                change = 1'b1;
            end
            @(negedge clk);
        end
        check("stream_count", got, 20);
        check("stream_left", exq_x.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
